// File: rtl/instr_issue.sv
// Instruction fetch/issue front end: fetches one word per PC, decodes fields, hands them to control.
// Optional macro ILLEGAL_HALT_EN: an illegal opcode halts the core instead of being skipped as a NOP.
module instr_issue #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  output logic        IMEM_READ,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_DATA,
  input  logic        STALL,
  output logic        INSTR_VALID,
  output logic [7:0]  OPCODE,
  output logic [2:0]  DEST,
  output logic [2:0]  SRC1,
  output logic [2:0]  SRC2,
  output logic [7:0]  IMMEDIATE,
  output logic        ILLEGAL,
  output logic [15:0] ISSUE_COUNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_illegal;
  logic [15:0] r_count;
  logic        w_capture;
  logic        w_bad_op;
  logic        w_issue;

  assign w_capture = (r_state == FETCH) && !IMEM_BUSYWAIT;
  assign w_bad_op  = IMEM_DATA[31:24] > 8'd5;
  assign w_issue   = (r_state == ISSUE) && !STALL;

  always_comb begin
    w_next      = r_state;
    IMEM_READ   = 1'b0;
    INSTR_VALID = 1'b0;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        IMEM_READ = 1'b1;
        if (w_capture) begin
          if (w_bad_op) begin
`ifdef ILLEGAL_HALT_EN
            w_next = HALT;
`else
            w_next = FETCH;
`endif
          end else begin
            w_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        INSTR_VALID = 1'b1;
        if (!STALL) w_next = FETCH;
      end
      HALT: w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= 32'd0;
      r_illegal <= 1'b0;
      r_count   <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_ir <= IMEM_DATA;
      if (w_capture && w_bad_op) r_illegal <= 1'b1;
      if (w_issue) begin
        r_pc    <= r_pc + PC_STEP;
        r_count <= r_count + 16'd1;
      end
`ifndef ILLEGAL_HALT_EN
      // Illegal word is skipped like a NOP: advance without ever issuing it.
      if (w_capture && w_bad_op) r_pc <= r_pc + PC_STEP;
`endif
    end
  end

  assign PC          = r_pc;
  assign OPCODE      = r_ir[31:24];
  assign DEST        = r_ir[18:16];
  assign SRC1        = r_ir[10:8];
  assign SRC2        = r_ir[2:0];
  assign IMMEDIATE   = r_ir[7:0];
  assign ILLEGAL     = r_illegal;
  assign ISSUE_COUNT = r_count;

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed scenarios then random traffic against a behavioural model.
module tb_instr_issue;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC;
  logic        IMEM_READ;
  logic        IMEM_BUSYWAIT = 1'b0;
  logic [31:0] IMEM_DATA = 32'd0;
  logic        STALL = 1'b0;
  logic        INSTR_VALID;
  logic [7:0]  OPCODE;
  logic [2:0]  DEST, SRC1, SRC2;
  logic [7:0]  IMMEDIATE;
  logic        ILLEGAL;
  logic [15:0] ISSUE_COUNT;

  logic        w_rst = 1'b0;
  logic [31:0] w_pc;
  logic        w_read, w_valid, w_ill;
  logic [7:0]  w_op, w_imm;
  logic [2:0]  w_dest, w_s1, w_s2;
  logic [15:0] w_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  instr_issue u_dut (
    .CLK(CLK), .RESET(RESET), .PC(PC), .IMEM_READ(IMEM_READ),
    .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .IMEM_DATA(IMEM_DATA), .STALL(STALL),
    .INSTR_VALID(INSTR_VALID), .OPCODE(OPCODE), .DEST(DEST), .SRC1(SRC1),
    .SRC2(SRC2), .IMMEDIATE(IMMEDIATE), .ILLEGAL(ILLEGAL), .ISSUE_COUNT(ISSUE_COUNT)
  );

  instr_issue #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(32'd4)) u_wrap (
    .CLK(CLK), .RESET(w_rst), .PC(w_pc), .IMEM_READ(w_read),
    .IMEM_BUSYWAIT(1'b0), .IMEM_DATA(32'h0000_0000), .STALL(1'b0),
    .INSTR_VALID(w_valid), .OPCODE(w_op), .DEST(w_dest), .SRC1(w_s1),
    .SRC2(w_s2), .IMMEDIATE(w_imm), .ILLEGAL(w_ill), .ISSUE_COUNT(w_cnt)
  );

  // Reference model: program position, what the core is doing, and the last word fetched.
  logic [31:0] mem [0:15];
  logic [31:0] m_pc;
  logic [31:0] m_word;
  logic [15:0] m_cnt;
  bit          m_ill;
  bit          m_running;   // left reset, fetching or issuing
  bit          m_holding;   // a legal word is being presented downstream
  bit          m_halted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!RESET) begin
      m_running = 0; m_holding = 0; m_halted = 0;
      m_pc = 32'd0; m_word = 32'd0; m_ill = 0; m_cnt = 16'd0;
    end else if (!m_running) begin
      m_running = 1;
    end else if (m_halted) begin
      // stays put until reset
    end else if (m_holding) begin
      if (!STALL) begin
        m_pc = m_pc + 32'd4;
        m_cnt = m_cnt + 16'd1;
        m_holding = 0;
      end
    end else if (!IMEM_BUSYWAIT) begin
      m_word = IMEM_DATA;
      if (IMEM_DATA[31:24] > 8'd5) begin
        m_ill = 1;
`ifdef ILLEGAL_HALT_EN
        m_halted = 1;
`else
        m_pc = m_pc + 32'd4;
`endif
      end else begin
        m_holding = 1;
      end
    end
  endtask

  task automatic check_all();
    check("pc", PC, m_pc);
    check("imem_read", IMEM_READ, m_running && !m_halted && !m_holding);
    check("instr_valid", INSTR_VALID, m_holding);
    check("opcode", OPCODE, m_word[31:24]);
    check("dest", DEST, m_word[18:16]);
    check("src1", SRC1, m_word[10:8]);
    check("src2", SRC2, m_word[2:0]);
    check("immediate", IMMEDIATE, m_word[7:0]);
    check("illegal", ILLEGAL, m_ill);
    check("issue_count", ISSUE_COUNT, m_cnt);
  endtask

  task automatic tick(input bit r, input bit b, input bit s);
    RESET = r;
    IMEM_BUSYWAIT = b;
    STALL = s;
    IMEM_DATA = b ? $urandom : mem[m_pc[5:2]];
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    m_pc = 0; m_word = 0; m_cnt = 0; m_ill = 0;
    m_running = 0; m_holding = 0; m_halted = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
    mem[0] = 32'h0502_0007;
    mem[1] = 32'h0103_0102;
    mem[2] = 32'h0900_0000;
    mem[3] = 32'h0201_0203;
    #1;

    tick(0, 0, 0);
    tick(0, 0, 0);
    check("rst_valid", INSTR_VALID, 1'b0);
    check("rst_pc", PC, 32'd0);

    tick(1, 0, 0);
    check("c1_read", IMEM_READ, 1'b1);
    tick(1, 0, 0);
    check("c2_valid", INSTR_VALID, 1'b1);
    check("c2_opcode", OPCODE, 8'd5);
    check("c2_dest", DEST, 3'd2);
    check("c2_imm", IMMEDIATE, 8'd7);
    tick(1, 0, 0);
    check("issue_pc", PC, 32'd4);
    check("issue_cnt", ISSUE_COUNT, 16'd1);

    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0);
      check("busy_read", IMEM_READ, 1'b1);
      check("busy_pc", PC, 32'd4);
      check("busy_valid", INSTR_VALID, 1'b0);
    end
    tick(1, 0, 0);
    check("after_busy_valid", INSTR_VALID, 1'b1);

    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 1);
      check("stall_valid", INSTR_VALID, 1'b1);
      check("stall_pc", PC, 32'd4);
      check("stall_opcode", OPCODE, 8'd1);
      check("stall_dest", DEST, 3'd3);
      check("stall_src1", SRC1, 3'd1);
      check("stall_src2", SRC2, 3'd2);
    end
    tick(1, 0, 0);
    check("unstall_pc", PC, 32'd8);

    tick(1, 0, 0);
    check("illegal_flag", ILLEGAL, 1'b1);
    check("illegal_valid", INSTR_VALID, 1'b0);
`ifdef ILLEGAL_HALT_EN
    check("halt_pc", PC, 32'd8);
    check("halt_read", IMEM_READ, 1'b0);
    for (int i = 0; i < 3; i++) tick(1, 0, 0);
    check("halt_stays", PC, 32'd8);
`else
    check("nop_pc", PC, 32'd12);
    check("nop_cnt", ISSUE_COUNT, 16'd2);
`endif

    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 0);
    tick(0, 1, 0);
    check("midfetch_rst_read", IMEM_READ, 1'b0);
    check("midfetch_rst_pc", PC, 32'd0);
    check("midfetch_rst_cnt", ISSUE_COUNT, 16'd0);

    for (int i = 0; i < 16; i++)
      mem[i] = {5'd0, 3'($urandom_range(0, 7)), 24'($urandom)};
    mem[7] = 32'h0800_0011;
    for (int c = 0; c < 3000; c++) begin
      bit r, b, s;
      r = ($urandom_range(0, 59) != 0);
      b = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 2) == 0);
      if (c % 500 == 499) mem[$urandom_range(0, 15)] = $urandom;
      tick(r, b, s);
    end

    w_rst = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
    w_rst = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    check("wrap_valid", w_valid, 1'b1);
    @(posedge CLK); #1;
    check("wrap_pc", w_pc, 32'd0);
    check("wrap_cnt", w_cnt, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter PC_STEP, default 32'd4, meaning the PC increment per issued instruction.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-low (0 = reset asserted).
REQ-005 SHALL have port PC  output  32  instruction memory address.
REQ-006 SHALL have port IMEM_READ  output  1  instruction memory read request.
REQ-007 SHALL have port IMEM_BUSYWAIT  input  1  memory busy; data is valid in a cycle with IMEM_READ=1 and IMEM_BUSYWAIT=0.
REQ-008 SHALL have port IMEM_DATA  input  32  fetched instruction word.
REQ-009 SHALL have port STALL  input  1  downstream hold request.
REQ-010 SHALL have port INSTR_VALID  output  1  decoded fields are valid for the control unit and register file.
REQ-011 SHALL have port OPCODE  output  8  instruction bits [31:24].
REQ-012 SHALL have port DEST  output  3  instruction bits [18:16].
REQ-013 SHALL have port SRC1  output  3  instruction bits [10:8].
REQ-014 SHALL have port SRC2  output  3  instruction bits [2:0].
REQ-015 SHALL have port IMMEDIATE  output  8  instruction bits [7:0].
REQ-016 SHALL have port ILLEGAL  output  1  sticky flag; the latched opcode is greater than 8'd5.
REQ-017 SHALL have port ISSUE_COUNT  output  16  count of issued instructions.

Function
REQ-018 SHALL implement the states IDLE, FETCH, ISSUE and HALT.
REQ-019 SHALL move IDLE->FETCH on the first edge at which RESET=1.
REQ-020 SHALL drive IMEM_READ=1 in FETCH only; IMEM_READ SHALL be 0 in every other state.
REQ-021 SHALL, in FETCH, at an edge where IMEM_BUSYWAIT=0, latch IMEM_DATA into the instruction register and move to ISSUE; while IMEM_BUSYWAIT=1 it SHALL stay in FETCH with PC unchanged.
REQ-022 SHALL drive all field outputs combinationally from the instruction register, which holds its value outside the FETCH capture.
REQ-023 SHALL drive INSTR_VALID=1 exactly while in ISSUE.
REQ-024 SHALL, in ISSUE, at an edge with STALL=0, apply PC <= PC + PC_STEP (modulo 2^32, wrapping silently), ISSUE_COUNT <= ISSUE_COUNT + 1 (wrapping 16'hFFFF->0), and move to FETCH.
REQ-025 SHALL, in ISSUE with STALL=1, hold its state, PC, the fields and ISSUE_COUNT.
REQ-026 SHALL have a minimum issue interval of 2 cycles (FETCH with zero wait, then ISSUE).
REQ-027 SHALL, on latching an opcode greater than 5, set ILLEGAL=1 in the same edge; handling of that opcode is defined in Configuration.
REQ-028 SHALL, in HALT, drive INSTR_VALID=0 and IMEM_READ=0, and leave HALT only by reset.
REQ-029 SHALL ignore STALL outside ISSUE.

Reset
REQ-030 SHALL, at any edge with RESET=0, and regardless of state (including mid-FETCH with BUSYWAIT=1), set state=IDLE, PC=RESET_PC, instruction register=0, ILLEGAL=0 and ISSUE_COUNT=0.
REQ-031 SHALL hold, from that edge, INSTR_VALID=0, IMEM_READ=0, OPCODE=0, DEST=0, SRC1=0, SRC2=0 and IMMEDIATE=0.
REQ-032 SHALL abandon an outstanding fetch on reset with no capture.

Configuration
REQ-033 SHALL, when macro ILLEGAL_HALT_EN is defined, move from FETCH to HALT on latching an illegal opcode, not enter ISSUE, and leave PC pointing at the illegal instruction.
REQ-034 SHALL, when ILLEGAL_HALT_EN is undefined, treat an illegal opcode as a NOP: go from FETCH directly back to FETCH with PC += PC_STEP, never assert INSTR_VALID for it, not increment ISSUE_COUNT, and still set ILLEGAL.

Verification
REQ-035 SHALL be tested with a zero-wait memory holding 0x05020007 at PC 0 -> INSTR_VALID on cycle 2 with OPCODE=5, DEST=2, IMMEDIATE=7; PC=4 after the issue edge; ISSUE_COUNT=1.
REQ-036 SHALL be tested with IMEM_BUSYWAIT=1 for 3 cycles -> IMEM_READ held high with PC constant, and INSTR_VALID first high one cycle after BUSYWAIT falls.
REQ-037 SHALL be tested with STALL=1 for 4 cycles during ISSUE of 0x01030102 -> fields, PC and INSTR_VALID=1 stable for 4 cycles, then PC advances by 4.
REQ-038 SHALL be tested with opcode 0x09 at PC 8 -> ILLEGAL=1; with ILLEGAL_HALT_EN, HALT with PC=8 and IMEM_READ=0; without it, PC=12 and ISSUE_COUNT unchanged.
REQ-039 SHALL be tested with RESET=0 during FETCH with BUSYWAIT=1 -> next cycle IMEM_READ=0, PC=RESET_PC and ISSUE_COUNT=0.
REQ-040 SHALL be tested with RESET_PC=32'hFFFFFFFC and one instruction issued -> PC wraps to 0.
